// File: rtl/pool_window_buffer.sv
// Collects a row-major pixel stream into non-overlapping 2x2 windows for the max-pool stage.
// Latency: window registered on the edge accepting its bottom-right pixel; no backpressure.
module pool_window_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic signed [DATA_W-1:0] pix_in,
    input  logic                     pix_valid,
    output logic signed [DATA_W-1:0] win_a,
    output logic signed [DATA_W-1:0] win_b,
    output logic signed [DATA_W-1:0] win_c,
    output logic signed [DATA_W-1:0] win_d,
    output logic                     win_valid,
    output logic                     frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [CW-1:0]              col_q, col_d, cur_col;
    logic [RW-1:0]              row_q, row_d, cur_row;
    logic signed [DATA_W-1:0]   held_q, held_d;
    logic signed [DATA_W-1:0]   wa_q, wa_d, wb_q, wb_d, wc_q, wc_d, wd_q, wd_d;
    logic                       win_valid_q, win_valid_d;
    logic                       frame_done_q, frame_done_d;
    logic                       lb_we;
    logic signed [DATA_W-1:0]   line_buf [IMG_W];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        held_d       = held_q;
        wa_d         = wa_q;
        wb_d         = wb_q;
        wc_d         = wc_q;
        wd_d         = wd_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        // A restart coinciding with a pixel makes that pixel (0,0).
        cur_col      = frame_start ? '0 : col_q;
        cur_row      = frame_start ? '0 : row_q;

        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end

        if (pix_valid) begin
            if (!cur_row[0]) begin
                lb_we = 1'b1;
            end else if (!cur_col[0]) begin
                held_d = pix_in;
            end else begin
                wa_d         = line_buf[cur_col & ~COL_ONE];
                wb_d         = line_buf[cur_col];
                wc_d         = held_q;
                wd_d         = pix_in;
                win_valid_d  = 1'b1;
                frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            end

            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
            end else begin
                col_d = cur_col + COL_ONE;
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            held_q       <= '0;
            wa_q         <= '0;
            wb_q         <= '0;
            wc_q         <= '0;
            wd_q         <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            held_q       <= held_d;
            wa_q         <= wa_d;
            wb_q         <= wb_d;
            wc_q         <= wc_d;
            wd_q         <= wd_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[cur_col] <= pix_in;
        end
    end

    assign win_a      = wa_q;
    assign win_b      = wb_q;
    assign win_c      = wc_q;
    assign win_d      = wd_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: a 4x2 instance for framing tests and a 2x2 instance for signed bytes.
module tb_pool_window_buffer;
    logic       clk;
    logic       rst_n;
    logic       fs4, vld4, fs2, vld2;
    logic [7:0] pix4, pix2;
    logic [7:0] a4, b4, c4, d4, a2, b2, c2, d2;
    logic       wv4, fd4, wv2, fd2;
    int         checks   = 0;
    int         failures = 0;
    int         strobes4 = 0;
    int         dones4   = 0;

    pool_window_buffer #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs4), .pix_in(pix4), .pix_valid(vld4),
        .win_a(a4), .win_b(b4), .win_c(c4), .win_d(d4),
        .win_valid(wv4), .frame_done(fd4)
    );

    pool_window_buffer #(.DATA_W(8), .IMG_W(2), .IMG_H(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs2), .pix_in(pix2), .pix_valid(vld2),
        .win_a(a2), .win_b(b2), .win_c(c2), .win_d(d2),
        .win_valid(wv2), .frame_done(fd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (wv4) strobes4++;
        if (wv4 && fd4) dones4++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the 4x2 instance; returns 1 ns after the edge.
    task automatic cyc4(input logic v, input logic [7:0] p, input logic fs);
        vld4 = v; pix4 = p; fs4 = fs;
        @(posedge clk); #1;
        vld4 = 1'b0; fs4 = 1'b0;
    endtask

    task automatic cyc2(input logic v, input logic [7:0] p);
        vld2 = v; pix2 = p;
        @(posedge clk); #1;
        vld2 = 1'b0;
    endtask

    // Feeds pixels base+1..base+8 with 'gap' idle cycles after each, checking every cycle.
    task automatic run_frame(input string tag, input int base, input int gap);
        logic [7:0] last_d;
        last_d = d4;
        for (int k = 1; k <= 8; k++) begin
            cyc4(1'b1, 8'(base + k), 1'b0);
            if (k == 6 || k == 8) begin
                chk({tag, "_valid"}, {7'd0, wv4}, 8'd1);
                chk({tag, "_done"},  {7'd0, fd4}, (k == 8) ? 8'd1 : 8'd0);
                chk({tag, "_a"}, a4, 8'(base + k - 5));
                chk({tag, "_b"}, b4, 8'(base + k - 4));
                chk({tag, "_c"}, c4, 8'(base + k - 1));
                chk({tag, "_d"}, d4, 8'(base + k));
                last_d = 8'(base + k);
            end else begin
                chk({tag, "_idle_valid"}, {7'd0, wv4}, 8'd0);
            end
            for (int g = 0; g < gap; g++) begin
                cyc4(1'b0, 8'hEE, 1'b0);
                chk({tag, "_gap_valid"}, {7'd0, wv4}, 8'd0);
                chk({tag, "_gap_hold"}, d4, last_d);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fs4 = 1'b0; vld4 = 1'b0; pix4 = 8'h00;
        fs2 = 1'b0; vld2 = 1'b0; pix2 = 8'h00;
        #12;
        chk("rst_a", a4, 8'h00);
        chk("rst_b", b4, 8'h00);
        chk("rst_c", c4, 8'h00);
        chk("rst_d", d4, 8'h00);
        chk("rst_valid", {7'd0, wv4}, 8'd0);
        chk("rst_done", {7'd0, fd4}, 8'd0);
        chk("rst2_valid", {7'd0, wv2}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame
        strobes4 = 0; dones4 = 0;
        run_frame("basic", 0, 0);
        cyc4(1'b0, 8'h00, 1'b0);
        chk("basic_after_valid", {7'd0, wv4}, 8'd0);
        chk("basic_hold_a", a4, 8'd3);
        chk("basic_strobes", 8'(strobes4), 8'd2);

        // Gapped input
        strobes4 = 0; dones4 = 0;
        run_frame("gap", 0, 3);
        chk("gap_strobes", 8'(strobes4), 8'd2);

        // frame_start mid-frame with a coincident pixel
        strobes4 = 0; dones4 = 0;
        for (int p = 1; p <= 5; p++) cyc4(1'b1, 8'(p), 1'b0);
        cyc4(1'b1, 8'd10, 1'b1);
        chk("fs_no_win", {7'd0, wv4}, 8'd0);
        for (int p = 11; p <= 17; p++) begin
            cyc4(1'b1, 8'(p), 1'b0);
            if (p == 15) begin
                chk("fs_w0_a", a4, 8'd10);
                chk("fs_w0_b", b4, 8'd11);
                chk("fs_w0_c", c4, 8'd14);
                chk("fs_w0_d", d4, 8'd15);
                chk("fs_w0_done", {7'd0, fd4}, 8'd0);
            end
        end
        chk("fs_w1_valid", {7'd0, wv4}, 8'd1);
        chk("fs_w1_a", a4, 8'd12);
        chk("fs_w1_b", b4, 8'd13);
        chk("fs_w1_c", c4, 8'd16);
        chk("fs_w1_d", d4, 8'd17);
        chk("fs_w1_done", {7'd0, fd4}, 8'd1);
        cyc4(1'b0, 8'h00, 1'b0);
        chk("fs_strobes", 8'(strobes4), 8'd2);

        // frame_start alone clears counters
        for (int p = 1; p <= 3; p++) cyc4(1'b1, 8'(p), 1'b0);
        cyc4(1'b0, 8'h00, 1'b1);
        chk("fs_only_valid", {7'd0, wv4}, 8'd0);

        // Asynchronous reset between edges
        for (int p = 1; p <= 6; p++) cyc4(1'b1, 8'(p), 1'b0);
        chk("ar_pre_valid", {7'd0, wv4}, 8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_a", a4, 8'h00);
        chk("ar_b", b4, 8'h00);
        chk("ar_c", c4, 8'h00);
        chk("ar_d", d4, 8'h00);
        chk("ar_valid", {7'd0, wv4}, 8'd0);
        #3 rst_n = 1'b1;
        strobes4 = 0; dones4 = 0;
        run_frame("ar_post", 0, 0);
        cyc4(1'b0, 8'h00, 1'b0);
        chk("ar_strobes", 8'(strobes4), 8'd2);

        // Back-to-back frames
        strobes4 = 0; dones4 = 0;
        run_frame("b2b_f0", 0, 0);
        run_frame("b2b_f1", 8, 0);
        cyc4(1'b0, 8'h00, 1'b0);
        chk("b2b_strobes", 8'(strobes4), 8'd4);
        chk("b2b_dones", 8'(dones4), 8'd2);

        // Signed pass-through on the 2x2 instance
        cyc2(1'b1, 8'h80);
        cyc2(1'b1, 8'h7F);
        cyc2(1'b1, 8'hFF);
        chk("sgn_early_valid", {7'd0, wv2}, 8'd0);
        cyc2(1'b1, 8'h00);
        chk("sgn_valid", {7'd0, wv2}, 8'd1);
        chk("sgn_done", {7'd0, fd2}, 8'd1);
        chk("sgn_a", a2, 8'h80);
        chk("sgn_b", b2, 8'h7F);
        chk("sgn_c", c2, 8'hFF);
        chk("sgn_d", d2, 8'h00);
        cyc2(1'b0, 8'h00);
        chk("sgn_pulse", {7'd0, wv2}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
